user_dma_ctrl: RTL and testbench

Word-granular DMA copy engine in the user project area, downstream of the management SoC's Wishbone bus and upstream of the user BRAM (mprjram). Firmware programs source, destination and length over Wishbone, pulses start, and the engine copies 32-bit words through a simple memory master port, then raises done and an optional interrupt. Firmware polls done and reports progress on the checkbits GPIOs.

---
 rtl/user_dma_pkg.sv | 29 ++
 rtl/user_dma_regs.sv | 124 ++++++++++++
 rtl/user_dma_ctrl.sv | 167 ++++++++++++++++
 tb/tb_user_dma_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_dma_pkg.sv
// Shared definitions for the user-area DMA copy engine: register map,
// control/status bit positions, transfer state encoding and a byte-lane helper.
package user_dma_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_SRC    = 3'd2;
   localparam logic [2:0] REG_DST    = 3'd3;
   localparam logic [2:0] REG_LEN    = 3'd4;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} dma_state_t;

   // Replace only the byte lanes selected by the Wishbone byte enables.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/user_dma_regs.sv
// Wishbone slave decode and register file for the DMA engine; produces the
// start pulse and transfer configuration, and tracks done/irq.
module user_dma_regs
   import user_dma_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic             busy,
   input  logic             fin,
   output logic             start_pulse,
   output logic [31:0]      cfg_src,
   output logic [31:0]      cfg_dst,
   output logic [LEN_W-1:0] cfg_len,
   output logic             irq
);

   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             start_q, start_d;
   logic             irq_en_q, irq_en_d;
   logic             done_q, done_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d;

   logic       access;
   logic [2:0] reg_sel;
   logic       unused_adr;

   assign access     = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign reg_sel    = wbs_adr_i[4:2];
   assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

   // Reads and writes both complete in the cycle the ack is registered.
   always_comb begin
      ack_d    = access;
      dat_d    = '0;
      start_d  = 1'b0;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;

      if (access && !wbs_we_i) begin
         case (reg_sel)
            REG_CTRL:   dat_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            REG_STATUS: begin
               dat_d[STATUS_BUSY_BIT] = busy;
               dat_d[STATUS_DONE_BIT] = done_q;
            end
            REG_SRC:    dat_d = src_q;
            REG_DST:    dat_d = dst_q;
            REG_LEN:    dat_d = 32'(len_q);
            default:    dat_d = '0;
         endcase
      end

      if (access && wbs_we_i) begin
         case (reg_sel)
            REG_CTRL: begin
               if (wbs_sel_i[0]) begin
                  irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
                  if (wbs_dat_i[CTRL_START_BIT] && !busy) begin
                     start_d = 1'b1;
                     done_d  = 1'b0;
                  end
               end
            end
            REG_STATUS: begin
               if (wbs_sel_i[0] && wbs_dat_i[STATUS_DONE_BIT]) done_d = 1'b0;
            end
            REG_SRC: if (!busy) src_d = merge_lanes(src_q, wbs_dat_i, wbs_sel_i);
            REG_DST: if (!busy) dst_d = merge_lanes(dst_q, wbs_dat_i, wbs_sel_i);
            REG_LEN: if (!busy) len_d = LEN_W'(merge_lanes(32'(len_q), wbs_dat_i, wbs_sel_i));
            default: ;
         endcase
      end

      // Completion must not be lost to a simultaneous clear.
      if (fin) done_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         start_q  <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         start_q  <= start_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign start_pulse = start_q;
   assign cfg_src     = src_q;
   assign cfg_dst     = dst_q;
   assign cfg_len     = len_q;
   assign irq         = done_q & irq_en_q;

endmodule

// File: rtl/user_dma_ctrl.sv
// Word-granular DMA copy engine: Wishbone-programmed register file plus a
// read-then-write transfer FSM driving a simple request/ack memory master.
module user_dma_ctrl
   import user_dma_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        irq
);

   dma_state_t       state_q, state_d;
   logic [31:0]      cur_src_q, cur_src_d;
   logic [31:0]      cur_dst_q, cur_dst_d;
   logic [LEN_W-1:0] remain_q, remain_d;
   logic [31:0]      data_q, data_d;
   logic             wr_done_q, wr_done_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;

   logic             start_pulse;
   logic [31:0]      cfg_src;
   logic [31:0]      cfg_dst;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;
   logic             fin;

   assign busy = (state_q != IDLE);
   assign fin  = (state_q == FIN);

   user_dma_regs #(.LEN_W(LEN_W)) u_regs (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .busy        (busy),
      .fin         (fin),
      .start_pulse (start_pulse),
      .cfg_src     (cfg_src),
      .cfg_dst     (cfg_dst),
      .cfg_len     (cfg_len),
      .irq         (irq)
   );

   // WR keeps a trailing idle cycle (wr_done) so mem_req always drops
   // between accesses while the next read can issue on entry to RD.
   always_comb begin
      state_d     = state_q;
      cur_src_d   = cur_src_q;
      cur_dst_d   = cur_dst_q;
      remain_d    = remain_q;
      data_d      = data_q;
      wr_done_d   = wr_done_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (start_pulse) begin
               cur_src_d = cfg_src;
               cur_dst_d = cfg_dst;
               remain_d  = cfg_len;
               if (cfg_len == '0) begin
                  state_d = FIN;
               end else begin
                  state_d    = RD;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = cfg_src;
               end
            end
         end
         RD: begin
            if (mem_req_q && mem_ack) begin
               data_d    = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = WR;
            end
         end
         WR: begin
            if (mem_req_q) begin
               if (mem_ack) begin
                  mem_req_d = 1'b0;
                  cur_src_d = cur_src_q + 32'd4;
                  cur_dst_d = cur_dst_q + 32'd4;
                  remain_d  = remain_q - LEN_W'(1);
                  wr_done_d = 1'b1;
               end
            end else if (wr_done_q) begin
               wr_done_d = 1'b0;
               if (remain_q == '0) begin
                  state_d = FIN;
               end else begin
                  state_d    = RD;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = cur_src_q;
               end
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = cur_dst_q;
               mem_wdata_d = data_q;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         cur_src_q   <= '0;
         cur_dst_q   <= '0;
         remain_q    <= '0;
         data_q      <= '0;
         wr_done_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_src_q   <= cur_src_d;
         cur_dst_q   <= cur_dst_d;
         remain_q    <= remain_d;
         data_q      <= data_d;
         wr_done_q   <= wr_done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_user_dma_ctrl.sv
// Directed bench for user_dma_ctrl: Wishbone programming, a behavioural
// memory with optional random wait states, and hand-computed expectations.
module tb_user_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        irq;

   logic [31:0] mem [0:255];
   logic [31:0] rd_addrs[$];
   logic [31:0] wr_addrs[$];

   int          checks = 0;
   int          errors = 0;
   int          wait_cnt, cur_delay, stab_err, req_seen;
   logic        pending, rand_delay;
   logic [31:0] s_addr, s_wdata;
   logic        s_we;

   always #5 clk = ~clk;

   user_dma_ctrl #(.LEN_W(16)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .irq       (irq)
   );

   // Behavioural memory: acks after cur_delay extra cycles of a held request
   // and flags any change of the request fields while waiting.
   always @(negedge clk) begin
      if (rst) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
         pending  = 1'b0;
      end else begin
         mem_ack = 1'b0;
         if (mem_req) begin
            req_seen++;
            if (pending && (mem_addr != s_addr || mem_wdata != s_wdata || mem_we != s_we))
               stab_err++;
            if (!pending) begin
               wait_cnt  = 0;
               cur_delay = rand_delay ? int'($urandom_range(0, 5)) : 0;
            end
            if (wait_cnt >= cur_delay) begin
               mem_ack = 1'b1;
               pending = 1'b0;
               if (mem_we) begin
                  mem[mem_addr[9:2]] = mem_wdata;
                  wr_addrs.push_back(mem_addr);
               end else begin
                  mem_rdata = mem[mem_addr[9:2]];
                  rd_addrs.push_back(mem_addr);
               end
            end else begin
               wait_cnt++;
               pending = 1'b1;
               s_addr  = mem_addr;
               s_wdata = mem_wdata;
               s_we    = mem_we;
            end
         end else begin
            pending = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [2:0] offs,
                                input logic [31:0] data, input logic [3:0] sel,
                                output logic [31:0] rdata);
      logic got;
      got   = 1'b0;
      rdata = '0;
      @(negedge clk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_adr_i = {27'd0, offs, 2'b00};
      wbs_dat_i = data;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            got   = 1'b1;
            rdata = wbs_dat_o;
            break;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      if (!got) checkOutput("wb_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wbWrite(input logic [2:0] offs, input logic [31:0] data);
      logic [31:0] dummy;
      applyStimulus(1'b1, offs, data, 4'hF, dummy);
   endtask

   task automatic wbRead(input logic [2:0] offs, output logic [31:0] data);
      applyStimulus(1'b0, offs, 32'd0, 4'hF, data);
   endtask

   task automatic startCopy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len);
      wbWrite(3'd2, src);
      wbWrite(3'd3, dst);
      wbWrite(3'd4, len);
      rd_addrs.delete();
      wr_addrs.delete();
      wbWrite(3'd0, 32'h3);
   endtask

   task automatic waitIrq(input int limit, output int cycles);
      cycles = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (irq) begin
            cycles = k;
            break;
         end
      end
   endtask

   function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] dummy;
      int          cyc;

      rst        = 1'b1;
      wbs_cyc_i  = 1'b0;
      wbs_stb_i  = 1'b0;
      wbs_we_i   = 1'b0;
      wbs_sel_i  = 4'h0;
      wbs_adr_i  = '0;
      wbs_dat_i  = '0;
      mem_rdata  = '0;
      rand_delay = 1'b0;
      stab_err   = 0;
      req_seen   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
      checkOutput("rst_wbs_dat", wbs_dat_o, 32'd0);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      wbRead(3'd2, rd);
      checkOutput("rst_src_reg", rd, 32'd0);
      wbRead(3'd1, rd);
      checkOutput("rst_status_reg", rd, 32'd0);

      wbWrite(3'd2, 32'h1234_5678);
      applyStimulus(1'b1, 3'd2, 32'hAAAA_AAAA, 4'b0011, dummy);
      wbRead(3'd2, rd);
      checkOutput("byte_lanes", rd, 32'h1234_AAAA);
      wbWrite(3'd5, 32'hFFFF_FFFF);
      wbRead(3'd5, rd);
      checkOutput("unmapped_read", rd, 32'd0);

      $display("[TB] basic copy");
      startCopy(32'h20, 32'h80, 32'd6);
      waitIrq(100, cyc);
      checkOutput("basic_cycles", 32'(cyc), 32'd26);
      wbRead(3'd1, rd);
      checkOutput("basic_status", rd, 32'h2);
      wbRead(3'd0, rd);
      checkOutput("ctrl_readback", rd, 32'h2);
      checkOutput("basic_nreads", 32'(rd_addrs.size()), 32'd6);
      checkOutput("basic_nwrites", 32'(wr_addrs.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         checkOutput("basic_rd_addr", qAt(rd_addrs, i), 32'h20 + 32'(4*i));
         checkOutput("basic_wr_addr", qAt(wr_addrs, i), 32'h80 + 32'(4*i));
         checkOutput("basic_data", mem[32+i], 32'hA500_0008 + 32'(i));
      end

      $display("[TB] zero length");
      req_seen = 0;
      wbWrite(3'd4, 32'd0);
      wbWrite(3'd0, 32'h3);
      waitIrq(20, cyc);
      checkOutput("zero_cycles", 32'(cyc), 32'd2);
      checkOutput("zero_no_req", 32'(req_seen), 32'd0);

      $display("[TB] start while busy");
      for (int i = 32; i < 38; i++) mem[i] = '0;
      startCopy(32'h20, 32'h80, 32'd6);
      wbWrite(3'd0, 32'h3);
      wbWrite(3'd2, 32'h100);
      waitIrq(200, cyc);
      checkOutput("busy_done", 32'(irq), 32'd1);
      checkOutput("busy_nwrites", 32'(wr_addrs.size()), 32'd6);
      checkOutput("busy_last_rd", qAt(rd_addrs, 5), 32'h34);
      wbRead(3'd2, rd);
      checkOutput("busy_src_kept", rd, 32'h20);

      $display("[TB] address wrap and interrupt");
      mem[255] = 32'hCAFE_0001;
      mem[0]   = 32'hCAFE_0002;
      startCopy(32'hFFFF_FFFC, 32'h200, 32'd2);
      waitIrq(50, cyc);
      checkOutput("wrap_cycles", 32'(cyc), 32'd10);
      checkOutput("wrap_rd0", qAt(rd_addrs, 0), 32'hFFFF_FFFC);
      checkOutput("wrap_rd1", qAt(rd_addrs, 1), 32'h0);
      checkOutput("wrap_data0", mem[128], 32'hCAFE_0001);
      checkOutput("wrap_data1", mem[129], 32'hCAFE_0002);
      wbRead(3'd1, rd);
      checkOutput("wrap_status", rd, 32'h2);
      wbWrite(3'd1, 32'h2);
      checkOutput("irq_cleared", 32'(irq), 32'd0);
      wbRead(3'd1, rd);
      checkOutput("done_cleared", rd, 32'h0);

      $display("[TB] memory wait states");
      mem[192] = 32'h3E;
      mem[193] = 32'h44;
      mem[194] = 32'h4A;
      mem[195] = 32'h50;
      for (int i = 208; i < 212; i++) mem[i] = '0;
      rand_delay = 1'b1;
      stab_err   = 0;
      startCopy(32'h300, 32'h340, 32'd4);
      waitIrq(400, cyc);
      rand_delay = 1'b0;
      checkOutput("ws_done", 32'(irq), 32'd1);
      checkOutput("ws_data0", mem[208], 32'h3E);
      checkOutput("ws_data1", mem[209], 32'h44);
      checkOutput("ws_data2", mem[210], 32'h4A);
      checkOutput("ws_data3", mem[211], 32'h50);
      checkOutput("ws_stable", 32'(stab_err), 32'd0);

      $display("[TB] reset mid-transfer");
      for (int i = 32; i < 38; i++) mem[i] = '0;
      startCopy(32'h20, 32'h80, 32'd6);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (wr_addrs.size() >= 2) break;
      end
      checkOutput("mid_two_writes", 32'(wr_addrs.size()), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("mid_mem_req", 32'(mem_req), 32'd0);
      checkOutput("mid_mem_we", 32'(mem_we), 32'd0);
      checkOutput("mid_mem_addr", mem_addr, 32'd0);
      checkOutput("mid_mem_wdata", mem_wdata, 32'd0);
      checkOutput("mid_wbs_ack", 32'(wbs_ack_o), 32'd0);
      checkOutput("mid_wbs_dat", wbs_dat_o, 32'd0);
      checkOutput("mid_irq", 32'(irq), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_word1_kept", mem[33], 32'hA500_0009);
      checkOutput("mid_word2_absent", mem[34], 32'd0);
      wbRead(3'd1, rd);
      checkOutput("mid_status_rst", rd, 32'd0);
      startCopy(32'h20, 32'h80, 32'd3);
      waitIrq(100, cyc);
      checkOutput("restart_cycles", 32'(cyc), 32'd14);
      checkOutput("restart_nwrites", 32'(wr_addrs.size()), 32'd3);
      checkOutput("restart_data", mem[34], 32'hA500_000A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
